// File: rtl/shifter_pkg.sv
// shifter_pkg: mode encodings and mux-level split helpers shared by pipe_shifter and its stages
package shifter_pkg;
   localparam logic [2:0] SH_SLL = 3'b000;
   localparam logic [2:0] SH_SRL = 3'b001;
   localparam logic [2:0] SH_SRA = 3'b011;
   localparam logic [2:0] SH_ROL = 3'b100;
   localparam logic [2:0] SH_ROR = 3'b101;
   // Earlier stages absorb the remainder when levels don't divide evenly
   function automatic int lvls_per_stage(input int lvls, input int stages, input int s);
      return lvls / stages + ((s < lvls % stages) ? 1 : 0);
   endfunction
   function automatic int lvl_lo(input int lvls, input int stages, input int s);
      int lo;
      lo = 0;
      for (int i = 0; i < s; i++) lo += lvls_per_stage(lvls, stages, i);
      return lo;
   endfunction
endpackage

// File: rtl/pipe_shifter_stage.sv
// shift_stage: mux levels LO_LVL..HI_LVL of the barrel shifter followed by one enabled pipeline register
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int TAGW = 5,
   parameter int LO_LVL = 0,
   parameter int HI_LVL = 0,
   parameter bit LAST = 1'b0,
   localparam int SAW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             i_valid,
   input  logic [WIDTH-1:0] i_d,
   input  logic [SAW-1:0]   i_sa,
   input  logic [2:0]       i_mode,
   input  logic             i_fill,
   input  logic             i_carry,
   input  logic [TAGW-1:0]  i_tag,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_d,
   output logic [SAW-1:0]   o_sa,
   output logic [2:0]       o_mode,
   output logic             o_fill,
   output logic             o_carry,
   output logic             o_zero,
   output logic [TAGW-1:0]  o_tag
);
   logic             valid_d, valid_q, fill_d, fill_q, carry_d, carry_q, zero_d, zero_q;
   logic [WIDTH-1:0] d_d, d_q;
   logic [SAW-1:0]   sa_d, sa_q;
   logic [2:0]       mode_d, mode_q;
   logic [TAGW-1:0]  tag_d, tag_q;

   function automatic logic [WIDTH-1:0] lvl(input logic [WIDTH-1:0] d, input logic [2:0] m,
                                             input logic f, input int n);
      logic [WIDTH-1:0] fm;
      fm = f ? ~({WIDTH{1'b1}} >> n) : '0;
      return m == SH_SLL ? d << n :
             (m == SH_SRL || m == SH_SRA) ? (d >> n) | fm :
             m == SH_ROL ? (d << n) | (d >> (WIDTH - n)) :
             m == SH_ROR ? (d >> n) | (d << (WIDTH - n)) : d;
   endfunction

   always_comb begin
      d_d = i_d;
      for (int k = LO_LVL; k <= HI_LVL; k++) d_d = i_sa[k] ? lvl(d_d, i_mode, i_fill, 1 << k) : d_d;
      valid_d = i_valid;
      sa_d = i_sa;
      mode_d = i_mode;
      fill_d = i_fill;
      carry_d = i_carry;
      tag_d = i_tag;
      zero_d = LAST ? (d_d == '0) : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         d_q <= '0;
         sa_q <= '0;
         mode_q <= '0;
         fill_q <= 1'b0;
         carry_q <= 1'b0;
         zero_q <= 1'b0;
         tag_q <= '0;
      end else if (en) begin
         valid_q <= valid_d;
         d_q <= d_d;
         sa_q <= sa_d;
         mode_q <= mode_d;
         fill_q <= fill_d;
         carry_q <= carry_d;
         zero_q <= zero_d;
         tag_q <= tag_d;
      end
   end

   assign o_valid = valid_q;
   assign o_d = d_q;
   assign o_sa = sa_q;
   assign o_mode = mode_q;
   assign o_fill = fill_q;
   assign o_carry = carry_q;
   assign o_zero = zero_q;
   assign o_tag = tag_q;
endmodule

// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined barrel shifter/rotator with valid/ready on both sides and a global stall
module pipe_shifter
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int STAGES = 2,
   parameter int TAGW = 5,
   localparam int SAW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_d,
   input  logic [SAW-1:0]   in_sa,
   input  logic [2:0]       in_mode,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sh,
   output logic             out_carry,
   output logic             out_zero,
   output logic [TAGW-1:0]  out_tag
);
   logic             advance, fill0, carry0;
   logic [SAW-1:0]   neg_sa, sa_m1;
   logic             v_w [0:STAGES];
   logic [WIDTH-1:0] d_w [0:STAGES];
   logic [SAW-1:0]   sa_w [0:STAGES];
   logic [2:0]       mode_w [0:STAGES];
   logic             fill_w [0:STAGES];
   logic             carry_w [0:STAGES];
   logic [TAGW-1:0]  tag_w [0:STAGES];
   logic [STAGES-1:0] zero_w;

   assign advance = out_ready || !out_valid;
   assign in_ready = advance;

   // Rotate carry equals the bit that wraps to the far end, which is the same input bit a shift would lose
   always_comb begin
      neg_sa = -in_sa;
      sa_m1 = in_sa - SAW'(1);
      fill0 = in_mode == SH_SRA && in_d[WIDTH-1];
      carry0 = in_sa == '0 ? 1'b0 :
               (in_mode == SH_SLL || in_mode == SH_ROL) ? in_d[neg_sa] :
               (in_mode == SH_SRL || in_mode == SH_SRA || in_mode == SH_ROR) ? in_d[sa_m1] : 1'b0;
   end

   assign v_w[0] = in_valid;
   assign d_w[0] = in_d;
   assign sa_w[0] = in_sa;
   assign mode_w[0] = in_mode;
   assign fill_w[0] = fill0;
   assign carry_w[0] = carry0;
   assign tag_w[0] = in_tag;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      localparam int LO = lvl_lo(SAW, STAGES, s);
      localparam int HI = LO + lvls_per_stage(SAW, STAGES, s) - 1;
      shift_stage #(
         .WIDTH(WIDTH), .TAGW(TAGW), .LO_LVL(LO), .HI_LVL(HI), .LAST(s == STAGES - 1)
      ) u_stage (
         .clk(clk), .rst_n(rst_n), .en(advance),
         .i_valid(v_w[s]), .i_d(d_w[s]), .i_sa(sa_w[s]), .i_mode(mode_w[s]),
         .i_fill(fill_w[s]), .i_carry(carry_w[s]), .i_tag(tag_w[s]),
         .o_valid(v_w[s+1]), .o_d(d_w[s+1]), .o_sa(sa_w[s+1]), .o_mode(mode_w[s+1]),
         .o_fill(fill_w[s+1]), .o_carry(carry_w[s+1]), .o_zero(zero_w[s]), .o_tag(tag_w[s+1])
      );
   end

   assign out_valid = v_w[STAGES];
   assign out_sh = d_w[STAGES];
   assign out_carry = carry_w[STAGES];
   assign out_zero = |zero_w;
   assign out_tag = tag_w[STAGES];
endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: directed and randomized checks of pipe_shifter (32b/2-stage and 8b/3-stage) against a bit-level model
module tb_pipe_shifter;
   typedef struct packed {
      logic [63:0] sh;
      logic        c;
      logic        z;
      logic [4:0]  tag;
   } exp_t;

   logic clk = 1'b0, rst_n = 1'b0;
   int vec = 0, errs = 0;

   logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_out_carry, a_out_zero;
   logic [31:0] a_in_d = '0, a_out_sh;
   logic [4:0]  a_in_sa = '0, a_in_tag = '0, a_out_tag;
   logic [2:0]  a_in_mode = '0;

   logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_carry, b_out_zero;
   logic [7:0]  b_in_d = '0, b_out_sh;
   logic [2:0]  b_in_sa = '0, b_in_mode = '0;
   logic [4:0]  b_in_tag = '0, b_out_tag;

   always #5 clk = ~clk;

   pipe_shifter #(.WIDTH(32), .STAGES(2), .TAGW(5)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_d(a_in_d),
      .in_sa(a_in_sa), .in_mode(a_in_mode), .in_tag(a_in_tag), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_sh(a_out_sh), .out_carry(a_out_carry), .out_zero(a_out_zero),
      .out_tag(a_out_tag)
   );

   pipe_shifter #(.WIDTH(8), .STAGES(3), .TAGW(5)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_d(b_in_d),
      .in_sa(b_in_sa), .in_mode(b_in_mode), .in_tag(b_in_tag), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_sh(b_out_sh), .out_carry(b_out_carry), .out_zero(b_out_zero),
      .out_tag(b_out_tag)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit-by-bit statement of each mode: where every result bit comes from, and which bit falls off
   function automatic exp_t model(input int w, input logic [63:0] d, input int sa, input logic [2:0] m,
                                  input logic [4:0] tag);
      exp_t e;
      e.sh = '0;
      e.c = 1'b0;
      for (int i = 0; i < w; i++)
         case (m)
            3'b000: e.sh[i] = (i >= sa) ? d[i-sa] : 1'b0;
            3'b001: e.sh[i] = (i + sa < w) ? d[i+sa] : 1'b0;
            3'b011: e.sh[i] = (i + sa < w) ? d[i+sa] : d[w-1];
            3'b100: e.sh[i] = d[(i - sa + w) % w];
            3'b101: e.sh[i] = d[(i + sa) % w];
            default: e.sh[i] = d[i];
         endcase
      if (sa != 0)
         e.c = (m == 3'b000) ? d[w-sa] : (m == 3'b001 || m == 3'b011) ? d[sa-1] :
               (m == 3'b100) ? e.sh[0] : (m == 3'b101) ? e.sh[w-1] : 1'b0;
      e.z = (e.sh == '0);
      e.tag = tag;
      return e;
   endfunction

   task automatic dir32(input string nm, input logic [31:0] d, input logic [4:0] sa, input logic [2:0] m,
                        input logic [4:0] tag, input logic [31:0] sh, input logic c, input logic z);
      @(negedge clk);
      a_in_valid = 1'b1; a_in_d = d; a_in_sa = sa; a_in_mode = m; a_in_tag = tag; a_out_ready = 1'b1;
      #1 chk({nm, ".in_ready"}, 64'(a_in_ready), 64'd1);
      @(negedge clk);
      a_in_valid = 1'b0;
      chk({nm, ".early_valid"}, 64'(a_out_valid), 64'd0);
      @(negedge clk);
      chk({nm, ".valid"}, 64'(a_out_valid), 64'd1);
      chk({nm, ".sh"}, 64'(a_out_sh), 64'(sh));
      chk({nm, ".carry"}, 64'(a_out_carry), 64'(c));
      chk({nm, ".zero"}, 64'(a_out_zero), 64'(z));
      chk({nm, ".tag"}, 64'(a_out_tag), 64'(tag));
   endtask

   initial begin
      exp_t qa[$], qb[$], e, ha, hb;
      logic [4:0] got[$];
      logic held, sta, stb;
      logic [31:0] hsh;
      logic [4:0] htag;
      int ptr, acc_b, cyc;

      // Reset with a request pending: nothing may enter or emerge
      a_in_valid = 1'b1; b_in_valid = 1'b1;
      #12;
      chk("rst.a_valid", 64'(a_out_valid), 64'd0);
      chk("rst.a_ready", 64'(a_in_ready), 64'd1);
      chk("rst.a_sh", 64'(a_out_sh), 64'd0);
      chk("rst.a_carry", 64'(a_out_carry), 64'd0);
      chk("rst.a_zero", 64'(a_out_zero), 64'd0);
      chk("rst.a_tag", 64'(a_out_tag), 64'd0);
      chk("rst.b_valid", 64'(b_out_valid), 64'd0);
      chk("rst.b_ready", 64'(b_in_ready), 64'd1);
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      dir32("sll31", 32'h0000_0001, 5'd31, 3'b000, 5'd1, 32'h8000_0000, 1'b0, 1'b0);
      dir32("sra4", 32'h8000_00F0, 5'd4, 3'b011, 5'd2, 32'hF800_000F, 1'b0, 1'b0);
      dir32("srl4", 32'h8000_00F0, 5'd4, 3'b001, 5'd3, 32'h0800_000F, 1'b0, 1'b0);
      dir32("rol1", 32'h8000_0001, 5'd1, 3'b100, 5'd4, 32'h0000_0003, 1'b1, 1'b0);
      dir32("ror1", 32'h0000_0001, 5'd1, 3'b101, 5'd5, 32'h8000_0000, 1'b1, 1'b0);
      dir32("sll31c", 32'h0000_0003, 5'd31, 3'b000, 5'd6, 32'h8000_0000, 1'b1, 1'b0);
      dir32("srl1z", 32'h0000_0001, 5'd1, 3'b001, 5'd7, 32'h0000_0000, 1'b1, 1'b1);
      dir32("rsvd", 32'h1234_5678, 5'd5, 3'b110, 5'd8, 32'h1234_5678, 1'b0, 1'b0);
      dir32("sa0", 32'h8765_4321, 5'd0, 3'b011, 5'd9, 32'h8765_4321, 1'b0, 1'b0);

      // Back-pressure: four requests, consumer stalled for three cycles once the first result lands
      ptr = 0; held = 1'b0; hsh = '0; htag = '0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (held) begin
            chk("bp.hold_valid", 64'(a_out_valid), 64'd1);
            chk("bp.hold_sh", 64'(a_out_sh), 64'(hsh));
            chk("bp.hold_tag", 64'(a_out_tag), 64'(htag));
         end
         a_in_valid = ptr < 4; a_in_tag = 5'(ptr + 1); a_in_d = 32'h0000_0011 << ptr;
         a_in_sa = 5'(ptr); a_in_mode = 3'b000; a_out_ready = c >= 5;
         #1;
         if (c == 2) chk("bp.stall_ready", 64'(a_in_ready), 64'd0);
         if (a_out_valid && !a_out_ready) chk("bp.in_ready", 64'(a_in_ready), 64'd0);
         if (a_out_valid && a_out_ready) got.push_back(a_out_tag);
         if (a_in_valid && a_in_ready) ptr++;
         held = a_out_valid && !a_out_ready; hsh = a_out_sh; htag = a_out_tag;
      end
      a_in_valid = 1'b0;
      chk("bp.count", 64'(got.size()), 64'd4);
      foreach (got[i]) chk("bp.order", 64'(got[i]), 64'(i + 1));

      // Random traffic on both configurations with random back-pressure
      acc_b = 0; cyc = 0; sta = 1'b0; stb = 1'b0; ha = '0; hb = '0;
      while (cyc < 60000 && !(acc_b >= 10000 && qa.size() == 0 && qb.size() == 0)) begin
         @(negedge clk);
         cyc++;
         if (sta) begin
            chk("ra.hold_valid", 64'(a_out_valid), 64'd1);
            chk("ra.hold", {a_out_sh, a_out_carry, a_out_zero, a_out_tag}, {ha.sh[31:0], ha.c, ha.z, ha.tag});
         end
         if (stb) begin
            chk("rb.hold_valid", 64'(b_out_valid), 64'd1);
            chk("rb.hold", {b_out_sh, b_out_carry, b_out_zero, b_out_tag}, {hb.sh[7:0], hb.c, hb.z, hb.tag});
         end
         a_in_valid = acc_b < 10000 && $urandom_range(0, 3) != 0;
         a_in_d = $urandom; a_in_sa = 5'($urandom); a_in_mode = 3'($urandom); a_in_tag = 5'($urandom);
         a_out_ready = $urandom_range(0, 3) != 0;
         b_in_valid = acc_b < 10000 && $urandom_range(0, 3) != 0;
         b_in_d = 8'($urandom); b_in_sa = 3'($urandom); b_in_mode = 3'($urandom); b_in_tag = 5'($urandom);
         b_out_ready = $urandom_range(0, 3) != 0;
         #1;
         if (a_in_valid && a_in_ready) qa.push_back(model(32, 64'(a_in_d), a_in_sa, a_in_mode, a_in_tag));
         if (b_in_valid && b_in_ready) begin
            qb.push_back(model(8, 64'(b_in_d), b_in_sa, b_in_mode, b_in_tag));
            acc_b++;
         end
         if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("ra.spurious", 64'(a_out_valid), 64'd0);
            else begin
               e = qa.pop_front();
               chk("ra.result", {a_out_sh, a_out_carry, a_out_zero, a_out_tag}, {e.sh[31:0], e.c, e.z, e.tag});
            end
         end
         if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("rb.spurious", 64'(b_out_valid), 64'd0);
            else begin
               e = qb.pop_front();
               chk("rb.result", {b_out_sh, b_out_carry, b_out_zero, b_out_tag}, {e.sh[7:0], e.c, e.z, e.tag});
            end
         end
         sta = a_out_valid && !a_out_ready; ha = '{64'(a_out_sh), a_out_carry, a_out_zero, a_out_tag};
         stb = b_out_valid && !b_out_ready; hb = '{64'(b_out_sh), b_out_carry, b_out_zero, b_out_tag};
      end
      chk("rand.finished", 64'(cyc < 60000), 64'd1);
      chk("rand.count_b", 64'(acc_b), 64'd10000);
      a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b1; b_out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("drain.a_valid", 64'(a_out_valid), 64'd0);
      chk("drain.b_valid", 64'(b_out_valid), 64'd0);

      // Abort: reset with two entries inside the 3-stage pipe, none may surface afterwards
      @(negedge clk);
      b_in_valid = 1'b1; b_in_d = 8'h5A; b_in_sa = 3'd1; b_in_mode = 3'b000; b_in_tag = 5'd7;
      @(negedge clk);
      b_in_tag = 5'd8;
      @(negedge clk);
      b_in_valid = 1'b0;
      chk("abort.pre_valid", 64'(b_out_valid), 64'd0);
      rst_n = 1'b0;
      #1;
      chk("abort.valid", 64'(b_out_valid), 64'd0);
      chk("abort.ready", 64'(b_in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("abort.post_valid", 64'(b_out_valid), 64'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/pipe_shifter.md
Name: pipe_shifter

Overview:
- Parametrised, pipelined successor to the CPU's combinational shifter.
- Supports logical left, logical right, arithmetic right, rotate left and rotate right.
- Reports a carry-out (last bit shifted out) and a zero flag.
- Built for the multi-cycle/pipelined datapath: sits behind the ALU issue point with valid/ready handshakes on both sides, so back-pressure from writeback stalls it cleanly.

Parameters:
- WIDTH, 32: data width; power of two, 8..64.
- STAGES, 2: register stages (latency); 1..$clog2(WIDTH).
- TAGW, 5: width of the sideband tag (destination register id) carried alongside the data.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset.
- in_valid  in  1  request present.
- in_ready  out  1  block accepts request this cycle.
- in_d  in  WIDTH  operand.
- in_sa  in  $clog2(WIDTH)  shift amount.
- in_mode  in  3  operation, encoded per pkg.
- in_tag  in  TAGW  sideband tag, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_sh  out  WIDTH  result.
- out_carry  out  1  last bit shifted or rotated out.
- out_zero  out  1  out_sh == 0.
- out_tag  out  TAGW  tag of this result.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low.
- Reset values: all stage valid bits 0, out_valid=0, out_sh=0, out_carry=0, out_zero=0, out_tag=0. in_ready=1 during and after reset.
- Reset mid-operation discards all in-flight entries immediately; no result is emitted for them.
- Modes (3-bit):
  - 000 SLL: zero fill.
  - 001 SRL: zero fill.
  - 011 SRA: fill with in_d[WIDTH-1].
  - 100 ROL and 101 ROR: bits wrap around.
  - Reserved codes 010, 110, 111: out_sh=in_d, out_carry=0.
- Datapath: log2(WIDTH) mux levels; level k shifts by 2^k when in_sa[k]=1.
  - Levels are split across STAGES as evenly as possible; earlier stages take the extra level when the split is uneven.
  - Each stage group is followed by a register.
  - Fill bits and mode are carried with the data through every stage.
- Carry is computed at stage 0 from in_d and in_sa, then piped along:
  - in_sa=0: 0 for every mode.
  - SLL: in_d[WIDTH-sa].
  - SRL and SRA: in_d[sa-1].
  - ROL: final out_sh[0].
  - ROR: final out_sh[WIDTH-1].
- out_zero is computed in the last stage from the final result.
- Latency: a request accepted on cycle N appears with out_valid=1 at cycle N+STAGES, provided there is no stall.
- Handshake:
  - Transfer in when in_valid && in_ready; transfer out when out_valid && out_ready.
  - Pipeline advances when advance = out_ready || !out_valid.
  - in_ready = advance (global stall).
  - Bubbles do not compress: when advance=0, every stage holds, including invalid ones.
- Output stability: while out_valid=1 and out_ready=0, out_sh, out_carry, out_zero and out_tag hold stable.
- Simultaneous events: input and output transfers in the same cycle are allowed, giving full throughput of one result per cycle.
- Inputs are sampled only when a transfer in occurs; otherwise they are don't-care.
- sa range: every sa value 0..WIDTH-1 is legal; no wrap beyond WIDTH-1 is possible given the in_sa width.

Decomposition:
- shifter_pkg:
  - mode localparams SH_SLL, SH_SRL, SH_SRA, SH_ROL, SH_ROR.
  - a function returning levels-per-stage for given WIDTH and STAGES.
- Sub-module shift_stage, instantiated STAGES times via generate. It contains:
  - a configurable range of mux levels (LO_LVL, HI_LVL parameters);
  - valid/data/sa/mode/carry/tag registers with an enable input.

Test Plan:
- Reset check: rst_n=0 with in_valid=1 -> out_valid=0 and in_ready=1. Release reset, send SLL d=0x0000_0001 sa=31 -> after 2 cycles out_sh=0x8000_0000, carry=0, zero=0.
- SRA: d=0x8000_00F0, sa=4 -> out_sh=0xF800_000F, carry=0. SRL of the same operand -> 0x0800_000F.
- Rotates: ROL d=0x8000_0001 sa=1 -> 0x0000_0003, carry=1. ROR d=0x0000_0001 sa=1 -> 0x8000_0000, carry=1.
- Zero flag: SLL d=0x0000_0003, sa=31 -> out_sh=0x8000_0000, carry=1. SRL d=0x1, sa=1 -> out_sh=0, zero=1, carry=1.
- Back-pressure: stream 4 back-to-back requests (tags 1..4) and hold out_ready=0 for 3 cycles.
  - in_ready drops once out_valid=1.
  - Outputs stay stable while stalled.
  - After release, tags emerge in order 1,2,3,4 with no loss or duplication.
- Parameter sweep and abort:
  - WIDTH=8, STAGES=3, random stimulus vs. reference model for 10k transactions: zero mismatches.
  - Assert rst_n=0 with 2 entries in flight: no results appear after reset is released.
